// File: rtl/uart_alu_engine.sv
// Framed command engine: parses opcode/len headers, echoes payloads or reduces
// little-endian operands with ADD/SUB/MUL, and drains malformed packets.
module uart_alu_engine #(
  parameter int OPERAND_WIDTH_P = 32,
  parameter int LEN_WIDTH_P     = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_ready_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic       busy_o,
  output logic       err_o
);

  localparam int B     = OPERAND_WIDTH_P / 8;
  localparam int IDX_W = $clog2(B) + 1;
  localparam logic [IDX_W-1:0]       IDX_LAST = IDX_W'(B - 1);
  localparam logic [IDX_W-1:0]       IDX_DONE = IDX_W'(B);
  localparam logic [IDX_W-1:0]       IDX_ONE  = IDX_W'(1);
  localparam logic [LEN_WIDTH_P-1:0] HDR_LEN  = LEN_WIDTH_P'(4);
  localparam logic [LEN_WIDTH_P-1:0] ONE      = LEN_WIDTH_P'(1);
  localparam logic [LEN_WIDTH_P-1:0] B_LEN    = LEN_WIDTH_P'(B);
  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hA0;
  localparam logic [7:0] OP_MUL  = 8'hA1;
  localparam logic [7:0] OP_SUB  = 8'hA2;

  typedef enum logic [2:0] {
    S_OPCODE, S_RESERVED, S_LEN_LO, S_LEN_HI, S_ECHO, S_OPERAND, S_RESULT, S_DRAIN
  } state_t;

  state_t                     state, state_next;
  logic [7:0]                 opcode, len_lo;
  logic [LEN_WIDTH_P-1:0]     cnt, len_full, payload;
  logic [OPERAND_WIDTH_P-1:0] acc, op_reg, op_asm, acc_shift;
  logic [IDX_W-1:0]           idx;
  logic                       first, err_next;
  logic                       rx_fire, tx_fire, tx_free, is_alu, bad_len, bad_multiple;

  function automatic logic [OPERAND_WIDTH_P-1:0] alu_reduce(
    input logic [7:0]                 opc,
    input logic [OPERAND_WIDTH_P-1:0] a,
    input logic [OPERAND_WIDTH_P-1:0] b
  );
    case (opc)
      OP_ADD:  alu_reduce = a + b;
      OP_SUB:  alu_reduce = a - b;
      default: alu_reduce = a * b;
    endcase
  endfunction

  assign rx_ready_o   = (state == S_RESULT) ? 1'b0 :
                        (state == S_ECHO)   ? tx_free : 1'b1;
  assign rx_fire      = rx_valid_i & rx_ready_o;
  assign tx_fire      = tx_valid_o & tx_ready_i;
  assign tx_free      = !tx_valid_o | tx_ready_i;
  assign busy_o       = (state != S_OPCODE);
  assign len_full     = {rx_data_i, len_lo};
  assign payload      = len_full - HDR_LEN;
  assign is_alu       = (opcode == OP_ADD) || (opcode == OP_MUL) || (opcode == OP_SUB);
  assign bad_len      = len_full < HDR_LEN;
  assign bad_multiple = (payload % B_LEN) != '0;
  // Operand bytes arrive LSB first, so each new byte enters at the top.
  assign op_asm       = (op_reg >> 8) | (OPERAND_WIDTH_P'(rx_data_i) << (OPERAND_WIDTH_P - 8));
  assign acc_shift    = acc >> {idx, 3'b000};

  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= S_OPCODE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    err_next   = 1'b0;
    case (state)
      S_OPCODE:   if (rx_fire) state_next = S_RESERVED;
      S_RESERVED: if (rx_fire) state_next = S_LEN_LO;
      S_LEN_LO:   if (rx_fire) state_next = S_LEN_HI;
      S_LEN_HI: begin
        if (rx_fire) begin
          if (bad_len) begin
            err_next   = 1'b1;
            state_next = S_OPCODE;
          end else if (opcode == OP_ECHO) begin
            state_next = (payload == '0) ? S_OPCODE : S_ECHO;
          end else if (!is_alu || payload == '0 || bad_multiple) begin
            err_next   = 1'b1;
            state_next = (payload == '0) ? S_OPCODE : S_DRAIN;
          end else begin
            state_next = S_OPERAND;
          end
        end
      end
      S_ECHO, S_DRAIN: if (rx_fire && cnt == ONE) state_next = S_OPCODE;
      S_OPERAND:       if (rx_fire && cnt == ONE) state_next = S_RESULT;
      S_RESULT:        if (tx_fire && idx == IDX_DONE) state_next = S_OPCODE;
      default:         state_next = S_OPCODE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      opcode     <= '0;
      len_lo     <= '0;
      cnt        <= '0;
      idx        <= '0;
      first      <= 1'b0;
      op_reg     <= '0;
      acc        <= '0;
      tx_data_o  <= '0;
      tx_valid_o <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      err_o <= err_next;
      if (tx_fire) tx_valid_o <= 1'b0;
      case (state)
        S_OPCODE: if (rx_fire) opcode <= rx_data_i;
        S_LEN_LO: if (rx_fire) len_lo <= rx_data_i;
        S_LEN_HI: begin
          if (rx_fire) begin
            cnt   <= payload;
            idx   <= '0;
            first <= 1'b1;
          end
        end
        S_ECHO: begin
          if (rx_fire) begin
            tx_data_o  <= rx_data_i;
            tx_valid_o <= 1'b1;
            cnt        <= cnt - ONE;
          end
        end
        S_DRAIN: if (rx_fire) cnt <= cnt - ONE;
        S_OPERAND: begin
          if (rx_fire) begin
            cnt    <= cnt - ONE;
            op_reg <= op_asm;
            if (idx == IDX_LAST) begin
              acc   <= first ? op_asm : alu_reduce(opcode, acc, op_asm);
              first <= 1'b0;
              idx   <= '0;
            end else begin
              idx <= idx + IDX_ONE;
            end
          end
        end
        // idx counts result bytes already loaded; a byte left over from an
        // earlier echo is allowed to drain before the first result byte.
        S_RESULT: begin
          if (tx_free && idx != IDX_DONE) begin
            tx_data_o  <= acc_shift[7:0];
            tx_valid_o <= 1'b1;
            idx        <= idx + IDX_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_engine.sv
// Scoreboarded random/directed bench for uart_alu_engine with a packet-level
// reference model and a negedge monitor checking every tx transfer.
module tb_uart_alu_engine;

  typedef logic [7:0] bytes_t[$];

  logic       clk = 1'b0;
  logic       rst_i;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic       rx_ready_o;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i;
  logic       busy_o;
  logic       err_o;

  logic [7:0] exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         exp_err = 0;
  int         err_seen = 0;
  int         tx_mode = 0;
  logic       hold_valid = 1'b0;
  logic [7:0] hold_data = 8'h00;
  logic [7:0] mon_exp;
  logic [7:0] alu_ops[3] = '{8'hA0, 8'hA1, 8'hA2};

  always #5 clk = ~clk;

  uart_alu_engine dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .rx_ready_o (rx_ready_o),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  initial begin
    tx_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (tx_mode)
        0:       tx_ready_i = 1'b1;
        1:       tx_ready_i = 1'($urandom_range(0, 1));
        default: tx_ready_i = 1'b0;
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        hold_valid = 1'b0;
      end else begin
        if (err_o) err_seen++;
        if (hold_valid) begin
          vectors++;
          if (!tx_valid_o || tx_data_o != hold_data) begin
            miscompares++;
            $display("FAIL tx_hold: valid=%0b data=%02h, required valid=1 data=%02h",
                     tx_valid_o, tx_data_o, hold_data);
          end
        end
        if (tx_valid_o && tx_ready_i) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL tx_extra: got byte %02h, required no byte", tx_data_o);
          end else begin
            mon_exp = exp_q.pop_front();
            if (tx_data_o != mon_exp) begin
              miscompares++;
              $display("FAIL tx_byte: got %02h, required %02h", tx_data_o, mon_exp);
            end
          end
        end
        hold_valid = tx_valid_o && !tx_ready_i;
        hold_data  = tx_data_o;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic bytes_t le_add(input bytes_t q, input logic [31:0] w);
    for (int i = 0; i < 4; i++) q.push_back(w[8*i +: 8]);
    return q;
  endfunction

  function automatic bytes_t mk_pkt(input logic [7:0] opc, input bytes_t pl);
    bytes_t     p;
    logic [15:0] len;
    len = 16'(pl.size() + 4);
    p = {opc, 8'($urandom_range(0, 255)), len[7:0], len[15:8]};
    foreach (pl[i]) p.push_back(pl[i]);
    return p;
  endfunction

  // Packet-level reference: what a correct engine must emit for one packet.
  task automatic model(input bytes_t p);
    longint unsigned m = 64'h1_0000_0000;
    longint unsigned acc, v;
    int len, pay, a;
    len = int'(p[3]) * 256 + int'(p[2]);
    pay = len - 4;
    if (len < 4) begin
      exp_err++;
    end else if (p[0] == 8'hEC) begin
      for (int i = 4; i < len; i++) exp_q.push_back(p[i]);
    end else if (!(p[0] inside {8'hA0, 8'hA1, 8'hA2}) || pay == 0 || pay % 4 != 0) begin
      exp_err++;
    end else begin
      acc = 0;
      for (int k = 0; k < pay / 4; k++) begin
        a = 4 + 4 * k;
        v = 64'(p[a]) + 64'(p[a+1]) * 64'd256 + 64'(p[a+2]) * 64'd65536 +
            64'(p[a+3]) * 64'd16777216;
        if (k == 0)             acc = v;
        else if (p[0] == 8'hA0) acc = (acc + v) % m;
        else if (p[0] == 8'hA2) acc = (acc + m - v) % m;
        else                    acc = (acc * v) % m;
      end
      for (int i = 0; i < 4; i++) exp_q.push_back(8'((acc >> (8 * i)) % 256));
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    bit took;
    if (gaps && $urandom_range(0, 3) == 0) begin
      rx_valid_i = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    t = 0;
    took = 1'b0;
    while (!took && t < 2000) begin
      @(negedge clk);
      took = rx_ready_o;
      @(posedge clk);
      #1;
      t++;
    end
    rx_valid_i = 1'b0;
    if (!took) begin
      vectors++;
      miscompares++;
      $display("FAIL rx_accept: byte %02h not taken in 2000 cycles, required acceptance", b);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((exp_q.size() != 0 || busy_o || tx_valid_o) && t < 5000);
    vectors++;
    if (t >= 5000) begin
      miscompares++;
      $display("FAIL idle_timeout: pending=%0d busy=%0b, required pending=0 busy=0",
               exp_q.size(), busy_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_packet(input bytes_t p, input bit gaps, input bit chk_lat, input int stall);
    if (stall > 0) tx_mode = 2;
    model(p);
    foreach (p[i]) send_byte(p[i], gaps);
    if (chk_lat) begin
      @(posedge clk);
      #1;
      check("result_latency", 64'(tx_valid_o), 64'd1);
    end
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1;
      check("stall_valid_held", 64'(tx_valid_o), 64'd1);
      check("stall_no_loss", 64'(exp_q.size()), 64'd4);
      tx_mode = 0;
    end
    wait_idle();
    check("err_count", 64'(err_seen), 64'(exp_err));
    check("busy_idle", 64'(busy_o), 64'd0);
  endtask

  initial begin
    bytes_t pl, p;
    int r, n;
    logic [7:0] opc;
    rst_i      = 1'b0;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", 64'(tx_valid_o), 64'd0);
    check("rst_tx_data",  64'(tx_data_o),  64'd0);
    check("rst_busy",     64'(busy_o),     64'd0);
    check("rst_err",      64'(err_o),      64'd0);
    check("rst_rx_ready", 64'(rx_ready_o), 64'd1);
    rst_i = 1'b1;
    @(posedge clk);
    #1;

    run_packet(mk_pkt(8'hEC, '{8'h11, 8'h22, 8'h33}), 1'b0, 1'b0, 0);
    pl = {}; pl = le_add(pl, 32'hFFFF_FFFF); pl = le_add(pl, 32'h0000_0002);
    run_packet(mk_pkt(8'hA0, pl), 1'b0, 1'b1, 0);
    pl = {}; pl = le_add(pl, 32'd10); pl = le_add(pl, 32'd3); pl = le_add(pl, 32'd4);
    run_packet(mk_pkt(8'hA2, pl), 1'b0, 1'b0, 0);
    pl = {}; pl = le_add(pl, 32'h0001_0000); pl = le_add(pl, 32'h0001_0000);
    run_packet(mk_pkt(8'hA1, pl), 1'b0, 1'b0, 0);
    run_packet(mk_pkt(8'h55, '{8'hAA, 8'hBB}), 1'b0, 1'b0, 0);
    run_packet(mk_pkt(8'hEC, '{8'h5A, 8'hA5, 8'hC3}), 1'b0, 1'b0, 0);
    run_packet(mk_pkt(8'hA0, '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05}), 1'b0, 1'b0, 0);
    run_packet('{8'hA0, 8'h00, 8'h02, 8'h00}, 1'b0, 1'b0, 0);
    run_packet(mk_pkt(8'hA1, '{}), 1'b0, 1'b0, 0);

    pl = {};
    for (int i = 0; i < 16; i++) pl.push_back(8'($urandom_range(0, 255)));
    tx_mode = 1;
    run_packet(mk_pkt(8'hEC, pl), 1'b0, 1'b0, 0);
    tx_mode = 0;
    pl = {}; pl = le_add(pl, 32'h1234_5678); pl = le_add(pl, 32'h1111_1111);
    run_packet(mk_pkt(8'hA0, pl), 1'b0, 1'b0, 20);

    // Reset while operands are being assembled.
    pl = {}; pl = le_add(pl, 32'hDEAD_BEEF); pl = le_add(pl, 32'h0000_0100);
    p = mk_pkt(8'hA0, pl);
    for (int i = 0; i < 9; i++) send_byte(p[i], 1'b0);
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_tx_valid", 64'(tx_valid_o), 64'd0);
    check("midrst_busy",     64'(busy_o),     64'd0);
    rst_i = 1'b1;
    pl = {}; pl = le_add(pl, 32'd5); pl = le_add(pl, 32'd7);
    run_packet(mk_pkt(8'hA0, pl), 1'b0, 1'b0, 0);

    for (int k = 0; k < 30; k++) begin
      tx_mode = $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      pl = {};
      if (r < 3) begin
        opc = 8'hEC;
        n = $urandom_range(0, 20);
      end else if (r < 8) begin
        opc = alu_ops[$urandom_range(0, 2)];
        n = 4 * $urandom_range(1, 4);
      end else if (r == 8) begin
        opc = 8'h55 + 8'($urandom_range(0, 15));
        n = $urandom_range(0, 5);
      end else begin
        opc = alu_ops[$urandom_range(0, 2)];
        n = $urandom_range(0, 7);
        if (n == 4) n = 5;
      end
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
      run_packet(mk_pkt(opc, pl), 1'b1, 1'b0, 0);
    end
    tx_mode = 0;

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
